// File: rtl/pc_sequencer.sv
// Program-counter sequencer: enable/stall, relative branch, absolute jump,
// and call/return through an internal return-address stack with sticky faults.
module pc_sequencer #(
    parameter int unsigned             PC_WIDTH    = 8,
    parameter int unsigned             STACK_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_offset,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                call,
    input  logic [PC_WIDTH-1:0] call_target,
    input  logic                ret,
    input  logic                err_clr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                ovf_err,
    output logic                unf_err
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] ras [STACK_DEPTH];
    logic [CNT_W-1:0]    count;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] ras_top;
    logic                do_push;
    logic                do_pop;
    logic                set_ovf;
    logic                set_unf;

    assign pc_inc      = pc + PC_WIDTH'(1);
    assign ras_top     = ras[IDX_W'(count - CNT_W'(1))];
    assign stack_empty = (count == CNT_W'(0));
    assign stack_full  = (count == CNT_W'(STACK_DEPTH));

    // Next-pc selection; priority ret > call > jump > branch > increment
    always_comb begin
        pc_next = pc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (en && !stall) begin
            if (ret) begin
                if (!stack_empty) begin
                    pc_next = ras_top;
                    do_pop  = 1'b1;
                end else begin
                    pc_next = pc_inc;
                    set_unf = 1'b1;
                end
            end else if (call) begin
                pc_next = call_target;
                if (!stack_full) begin
                    do_push = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end else if (jump) begin
                pc_next = jump_target;
            end else if (branch_taken) begin
                // same-width add is sign-extension modulo 2^PC_WIDTH
                pc_next = pc + branch_offset;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    // pc, stack depth and sticky fault flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pc <= pc_next;
            if (do_push) begin
                count <= count + CNT_W'(1);
            end else if (do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (set_ovf) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (set_unf) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

    // Stack entries carry no reset; only slots below count are ever read
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            ras[IDX_W'(count)] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_WIDTH=8, STACK_DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       jump;
    logic [7:0] jump_target;
    logic       call;
    logic [7:0] call_target;
    logic       ret;
    logic       err_clr;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic       stack_empty;
    logic       stack_full;
    logic       ovf_err;
    logic       unf_err;

    int checks;
    int failures;

    pc_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .call(call), .call_target(call_target),
        .ret(ret), .err_clr(err_clr),
        .pc(pc), .pc_next(pc_next),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_taken = 1'b0;
        jump         = 1'b0;
        call         = 1'b0;
        ret          = 1'b0;
        err_clr      = 1'b0;
        stall        = 1'b0;
        en           = 1'b1;
    endtask

    task automatic goto(input logic [7:0] t);
        idle();
        jump        = 1'b1;
        jump_target = t;
        step();
        jump = 1'b0;
    endtask

    task automatic do_call(input logic [7:0] t, input logic [7:0] exp_pc);
        idle();
        call        = 1'b1;
        call_target = t;
        step();
        call = 1'b0;
        chk("call_pc", 32'(pc), 32'(exp_pc));
    endtask

    task automatic do_ret(input logic [7:0] exp_pc);
        idle();
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk("ret_pc", 32'(pc), 32'(exp_pc));
    endtask

    logic [7:0] exp_pc;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        en = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_offset = 8'h00;
        jump = 1'b0;
        jump_target = 8'h00;
        call = 1'b0;
        call_target = 8'h00;
        ret = 1'b0;
        err_clr = 1'b0;

        // 1: async reset mid-cycle, then free-running increment with wrap
        #3 rst = 1'b1;
        #1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk("rst_full", 32'(stack_full), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_unf", 32'(unf_err), 32'd0);
        step();
        rst = 1'b0;
        en  = 1'b1;
        #1;
        exp_pc = 8'h00;
        for (int i = 0; i < 300; i++) begin
            chk("inc_pc", 32'(pc), 32'(exp_pc));
            chk("inc_pc_next", 32'(pc_next), 32'(8'(exp_pc + 8'h01)));
            step();
            exp_pc = exp_pc + 8'h01;
        end
        chk("inc_wrapped", 32'(pc), 32'h2C);

        // 2: stall overrides a jump; en=0 holds
        goto(8'h10);
        chk("goto10", 32'(pc), 32'h10);
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 8'h80;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_pc_next", 32'(pc_next), 32'h10);
            step();
            chk("stall_pc", 32'(pc), 32'h10);
        end
        idle();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("hold_pc_next", 32'(pc_next), 32'h10);
            step();
            chk("hold_pc", 32'(pc), 32'h10);
        end

        // 3: negative branch, then jump beats branch
        goto(8'h20);
        branch_taken  = 1'b1;
        branch_offset = 8'hF0;
        #1 chk("branch_pc_next", 32'(pc_next), 32'h10);
        step();
        chk("branch_pc", 32'(pc), 32'h10);
        jump        = 1'b1;
        jump_target = 8'h55;
        step();
        chk("jump_prio_pc", 32'(pc), 32'h55);
        idle();

        // 4: nested calls to full, overflow call, unwind
        goto(8'h03);
        do_call(8'h40, 8'h40);
        chk("call1_empty", 32'(stack_empty), 32'd0);
        do_call(8'h50, 8'h50);
        do_call(8'h60, 8'h60);
        do_call(8'h70, 8'h70);
        chk("full_after4", 32'(stack_full), 32'd1);
        chk("no_ovf_yet", 32'(ovf_err), 32'd0);
        do_call(8'h90, 8'h90);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("full_hold", 32'(stack_full), 32'd1);
        do_ret(8'h61);
        chk("not_full", 32'(stack_full), 32'd0);
        do_ret(8'h51);
        do_ret(8'h41);
        do_ret(8'h04);
        chk("empty_after_unwind", 32'(stack_empty), 32'd1);

        // 5: underflow, sticky hold, clear, clear colliding with fault
        goto(8'h30);
        do_ret(8'h31);
        chk("unf_set", 32'(unf_err), 32'd1);
        idle();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("unf_sticky", 32'(unf_err), 32'd1);
        end
        err_clr = 1'b1;
        step();
        chk("unf_cleared", 32'(unf_err), 32'd0);
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        chk("clr_pc_hold", 32'(pc), 32'h31);
        idle();
        ret     = 1'b1;
        err_clr = 1'b1;
        step();
        chk("unf_set_wins", 32'(unf_err), 32'd1);
        chk("unf2_pc", 32'(pc), 32'h32);
        idle();

        // 6: ret beats call; reset aborts an in-flight call
        goto(8'h21);
        do_call(8'h80, 8'h80);
        ret         = 1'b1;
        call        = 1'b1;
        call_target = 8'h99;
        step();
        chk("ret_prio_pc", 32'(pc), 32'h22);
        chk("ret_prio_empty", 32'(stack_empty), 32'd1);
        idle();
        call        = 1'b1;
        call_target = 8'h44;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_pc", 32'(pc), 32'h00);
        chk("async_rst_empty", 32'(stack_empty), 32'd1);
        chk("async_rst_unf", 32'(unf_err), 32'd0);
        step();
        chk("rst_held_pc", 32'(pc), 32'h00);
        chk("rst_held_empty", 32'(stack_empty), 32'd1);
        rst  = 1'b0;
        call = 1'b0;
        step();
        chk("post_rst_inc", 32'(pc), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the lab CPU datapath. Replaces the free-running increment-only counter with an enable, stall, relative branch, absolute jump, and call/return using an internal return-address stack (RAS). It drives the instruction-memory address and reports stack status and faults to the control unit.

Parameters:
PC_WIDTH, 8, width of pc and all address/offset ports (>=2)
STACK_DEPTH, 4, number of RAS entries (>=1)
RESET_PC, 0, value loaded into pc on reset

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
en  input  1  advance enable; when low pc holds
stall  input  1  pipeline stall; overrides every operation, pc and RAS hold
branch_taken  input  1  relative branch request
branch_offset  input  PC_WIDTH  signed two's-complement offset added to current pc
jump  input  1  absolute jump request
jump_target  input  PC_WIDTH  absolute jump destination
call  input  1  call request: push pc+1, go to call_target
call_target  input  PC_WIDTH  call destination
ret  input  1  return request: pop RAS into pc
err_clr  input  1  synchronous clear of sticky fault flags
pc  output  PC_WIDTH  current program counter (registered)
pc_next  output  PC_WIDTH  combinational value pc takes at the next rising edge
stack_empty  output  1  RAS holds 0 entries
stack_full  output  1  RAS holds STACK_DEPTH entries
ovf_err  output  1  sticky: call attempted while full
unf_err  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, RAS count=0 (stack_empty=1, stack_full=0), ovf_err=0, unf_err=0. Entry contents are don't-care. Asserting rst mid-operation aborts any pending op immediately. No op executes on the edge where rst deasserts while still high.
- An op is active on a rising edge when en=1 and stall=0. Otherwise pc, RAS, and count hold, and pc_next=pc.
- Priority when several requests are high in one active cycle: ret > call > jump > branch_taken > increment. Only the winning op executes; the others are ignored with no side effects.
  - ret, count>0: pc <= top entry, count-1.
  - ret, count==0: pc <= pc+1, unf_err <= 1.
  - call, count<STACK_DEPTH: push (pc+1), pc <= call_target, count+1.
  - call, count==STACK_DEPTH: pc <= call_target, no push, no stack change, ovf_err <= 1.
  - jump: pc <= jump_target.
  - branch_taken: pc <= pc + sign-extended branch_offset.
  - Default: pc <= pc+1.
- Arithmetic is modulo 2^PC_WIDTH. Wrap-around is silent and raises no flag (for example, 8-bit 0xFF+1=0x00, 0x02+0xFC=0xFE). The pushed return address also wraps.
- pc_next is purely combinational from current state and inputs, uses the same priority, and equals pc on the following edge when rst=0.
- RAS is LIFO. stack_empty and stack_full are registered-state decodes, updated the cycle after a push or pop.
- Sticky flags:
  - Set only by the faults above.
  - Cleared by err_clr=1 on a rising edge regardless of en or stall.
  - If a fault and err_clr coincide, the set wins (flag=1).
- Single-cycle latency for all ops. There is no handshake; the control unit guarantees request stability at the clock edge.

Test Plan:
1. Reset and increment: rst pulse mid-cycle, then en=1 for 300 cycles (PC_WIDTH=8) -> pc=0 immediately on rst; counts 0,1,…,0xFF,0x00 (wrap), pc_next always pc+1.
2. Stall/enable hold: at pc=0x10, stall=1 with jump=1 and target 0x80 for 3 cycles, then en=0 for 2 cycles -> pc stays 0x10 throughout; pc_next=0x10.
3. Branch/jump: at pc=0x20, branch_offset=0xF0 -> pc=0x10. Next, jump=1 and branch_taken=1 together with target 0x55 -> pc=0x55 (jump wins).
4. Nested call/return (STACK_DEPTH=4): calls at pc=0x03,0x40,0x50,0x60 -> stack_full=1. A 5th call at 0x70 with target 0x90 -> pc=0x90, ovf_err=1. Four rets -> pc=0x61,0x51,0x41,0x04, stack_empty=1.
5. Underflow and clear: ret on empty stack at pc=0x30 -> pc=0x31, unf_err=1. The flag stays set over 5 cycles. err_clr=1 -> 0. err_clr together with a new underflow -> unf_err stays 1.
6. Priority and async reset: ret and call together with count=1, top=0x22 -> pc=0x22, no push. Then a call in progress with rst asserted between edges -> pc=RESET_PC, stack_empty=1 before the next edge.
